// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-ported memory; optional MEM_ARB_RR_EN selects round-robin conflict policy.
// Latency: grant in cycle 0, LATENCY memory cycles, valid pulse in cycle LATENCY+1, next grant from LATENCY+2.
// Backpressure: requests are held by the requester until granted; nothing is granted while a transaction is in flight.
module mem_port_arbiter #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_grant,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_grant,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // Counter starts at LATENCY-1 so the ACCESS phase lasts exactly LATENCY cycles.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        own_d_q, own_d_d;      // 1 = data port owns the current transaction
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        grant_if, grant_d;

`ifdef MEM_ARB_RR_EN
    logic        last_d_q, last_d_d;    // 1 = data port was granted last
`endif

    // Grant selection: only in IDLE and never while reset is asserted.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (!reset && state_q == ST_IDLE) begin
            if (if_req && d_req) begin
`ifdef MEM_ARB_RR_EN
                // Conflict goes to the port that did not win last time.
                grant_d  = !last_d_q;
                grant_if = last_d_q;
`else
                // Conflict always goes to the data port.
                grant_d  = 1'b1;
`endif
            end else begin
                grant_if = if_req;
                grant_d  = d_req;
            end
        end
    end

    // Next-state logic for the transaction FSM and its latched operands.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        own_d_d    = own_d_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
`ifdef MEM_ARB_RR_EN
        last_d_d   = last_d_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_if || grant_d) begin
                    state_d = ST_ACCESS;
                    cnt_d   = CNT_LOAD;
                    own_d_d = grant_d;
                    addr_d  = grant_d ? d_addr : if_addr;
                    we_d    = grant_d && d_we;
                    // Fetches never write; park write data at zero for them.
                    wdata_d = grant_d ? d_wdata : 32'h0;
`ifdef MEM_ARB_RR_EN
                    last_d_d = grant_d;
`endif
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    // Read data is taken on the final memory cycle; writes leave rdata alone.
                    if (!we_q) begin
                        if (own_d_q) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            if_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            we_q       <= 1'b0;
            own_d_q    <= 1'b0;
            if_rdata_q <= 32'h0;
            d_rdata_q  <= 32'h0;
`ifdef MEM_ARB_RR_EN
            last_d_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            own_d_q    <= own_d_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
            last_d_q   <= last_d_d;
`endif
        end
    end

    assign if_grant  = grant_if;
    assign d_grant   = grant_d;
    assign if_valid  = (state_q == ST_RESP) && !own_d_q;
    assign d_valid   = (state_q == ST_RESP) && own_d_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_read  = (state_q == ST_ACCESS) && !we_q;
    assign mem_write = (state_q == ST_ACCESS) && we_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: LATENCY=2 instance with a small memory model, plus a LATENCY=1 instance.
// Expected responses are queued when requests are driven and popped when a valid pulse appears.
// Conflict expectations follow MEM_ARB_RR_EN when the bench is built with it.
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_grant, if_valid, d_grant, d_valid;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, busy;

    logic        if_req1;
    logic [31:0] if_addr1;
    logic        d_req1, d_we1;
    logic [31:0] d_addr1, d_wdata1;
    logic        if_grant1, if_valid1, d_grant1, d_valid1;
    logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic        mem_read1, mem_write1, busy1;

    typedef struct packed {
        logic        port;     // 1 = data port
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [31:0] mem [0:15];

    always #5 clk = ~clk;

    mem_port_arbiter #(.LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_grant(if_grant), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_grant(d_grant), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .if_req(if_req1), .if_addr(if_addr1), .if_grant(if_grant1), .if_valid(if_valid1), .if_rdata(if_rdata1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_grant(d_grant1), .d_valid(d_valid1), .d_rdata(d_rdata1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_read(mem_read1), .mem_write(mem_write1),
        .mem_rdata(mem_rdata1), .busy(busy1)
    );

    // Memory model: a few preloaded words, writes land on the clock edge.
    always @(posedge clk) begin
        if (reset) begin
            mem[4]  <= 32'hDEADBEEF;
            mem[9]  <= 32'h5555AAAA;
            mem[12] <= 32'hCAFE0000;
        end else if (mem_write) begin
            mem[mem_addr[5:2]] <= mem_wdata;
        end
    end
    assign mem_rdata  = mem[mem_addr[5:2]];
    assign mem_rdata1 = {16'hA5A5, mem_addr1[15:0]};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Per-cycle invariants and scoreboard pops on valid pulses.
    always @(negedge clk) begin
        check("excl_grant", 32'(if_grant & d_grant), 32'd0);
        check("excl_valid", 32'(if_valid & d_valid), 32'd0);
        check("excl_strobe", 32'(mem_read & mem_write), 32'd0);
        if (if_valid || d_valid) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_valid", 32'(if_valid | d_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_port", 32'(d_valid), 32'(e.port));
                check("sb_rdata", d_valid ? d_rdata : if_rdata, e.rdata);
            end
        end
    end

    task automatic push_exp(input logic port, input logic [31:0] rdata);
        exp_t e;
        e.port  = port;
        e.rdata = rdata;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One isolated transaction on the LATENCY=2 instance with cycle-by-cycle checks.
    task automatic single(input logic is_d, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd);
        @(posedge clk); #1;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        @(negedge clk);
        check("grant_if", 32'(if_grant), 32'(!is_d));
        check("grant_d", 32'(d_grant), 32'(is_d));
        push_exp(is_d, exp_rd);
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            check("acc_read", 32'(mem_read), 32'(!we));
            check("acc_write", 32'(mem_write), 32'(we));
            check("acc_addr", mem_addr, addr);
            if (we) check("acc_wdata", mem_wdata, wdata);
            check("acc_busy", 32'(busy), 32'd1);
            check("acc_novalid", 32'(if_valid | d_valid), 32'd0);
        end
        @(negedge clk);
        check("resp_valid", 32'(is_d ? d_valid : if_valid), 32'd1);
        check("resp_strobe", 32'(mem_read | mem_write), 32'd0);
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_valid", 32'(if_valid | d_valid), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, reads, valids;
        logic wd;
        reset = 1'b1;
        if_req = 1'b1; if_addr = 32'h0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        if_req1 = 1'b0; if_addr1 = 32'h0; d_req1 = 1'b0; d_we1 = 1'b0; d_addr1 = 32'h0; d_wdata1 = 32'h0;

        // Reset state, with both requests high to show grants are suppressed.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grants", 32'(if_grant | d_grant), 32'd0);
        check("rst_valids", 32'(if_valid | d_valid), 32'd0);
        check("rst_strobes", 32'(mem_read | mem_write), 32'd0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0; if_req = 1'b0; d_req = 1'b0;

        // Fetch read, data read, data write, data read-back.
        single(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
        check("fetch_rdata_hold", if_rdata, 32'hDEADBEEF);
        single(1'b1, 1'b0, 32'h24, 32'h0, 32'h5555AAAA);
        single(1'b1, 1'b1, 32'h20, 32'h1234, 32'h5555AAAA);
        check("write_keeps_d_rdata", d_rdata, 32'h5555AAAA);
        single(1'b1, 1'b0, 32'h20, 32'h0, 32'h1234);
        check("if_rdata_untouched", if_rdata, 32'hDEADBEEF);

        // Reset during the last ACCESS cycle of a fetch aborts it.
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h30;
        @(negedge clk);
        check("abort_grant", 32'(if_grant), 32'd1);
        @(posedge clk); #1;
        if_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(if_valid | d_valid), 32'd0);
        check("abort_if_rdata", if_rdata, 32'h0);
        check("abort_d_rdata", d_rdata, 32'h0);
        check("abort_grant_in_reset", 32'(d_grant | if_grant), 32'd0);
        check("abort_strobe", 32'(mem_read), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        push_exp(1'b1, 32'h1234);
        @(negedge clk);
        check("post_reset_grant", 32'(d_grant), 32'd1);
        @(posedge clk); #1;
        d_req = 1'b0;
        repeat (4) @(negedge clk);

        // Both ports held high for four transactions.
        do_reset();
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            wd = (k % 2 == 0);
`else
            wd = 1'b1;
`endif
            push_exp(wd, wd ? 32'h1234 : 32'hDEADBEEF);
        end
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            wd = (k % 2 == 0);
`else
            wd = 1'b1;
`endif
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(if_grant || d_grant) && n < 20);
            check("conf_d_grant", 32'(d_grant), 32'(wd));
            check("conf_if_grant", 32'(if_grant), 32'(!wd));
            check("conf_gap", 32'(n), (k == 0) ? 32'd1 : 32'(LAT + 2));
        end
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0;
        repeat (5) @(negedge clk);

        // LATENCY=1: back-to-back fetches.
        @(posedge clk); #1;
        if_req1 = 1'b1; if_addr1 = 32'h40;
        for (int k = 0; k < 3; k++) begin
            n = 0; reads = 0; valids = 0;
            do begin
                @(negedge clk);
                n++;
                reads += int'(mem_read1);
                if (if_valid1) begin
                    valids++;
                    check("l1_rdata", if_rdata1, 32'hA5A50040);
                end
            end while (!if_grant1 && n < 20);
            check("l1_grant", 32'(if_grant1), 32'd1);
            if (k > 0) begin
                check("l1_gap", 32'(n), 32'd3);
                check("l1_reads", 32'(reads), 32'd1);
                check("l1_valids", 32'(valids), 32'd1);
            end
        end
        @(posedge clk); #1;
        if_req1 = 1'b0;
        reads = 0; valids = 0;
        repeat (3) begin
            @(negedge clk);
            reads += int'(mem_read1);
            valids += int'(if_valid1);
        end
        check("l1_last_reads", 32'(reads), 32'd1);
        check("l1_last_valids", 32'(valids), 32'd1);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: LATENCY, default 2, memory access cycles per transaction; legal range 1..15.
REQ-002 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: if_req  in  1  fetch requester wants a read.
REQ-005 Port: if_addr  in  32  fetch address.
REQ-006 Port: if_grant  out  1  fetch request accepted this cycle.
REQ-007 Port: if_valid  out  1  one-cycle pulse; if_rdata valid.
REQ-008 Port: if_rdata  out  32  fetch read data.
REQ-009 Port: d_req  in  1  data requester wants an access.
REQ-010 Port: d_we  in  1  1 = write, 0 = read.
REQ-011 Port: d_addr  in  32  data address.
REQ-012 Port: d_wdata  in  32  write data.
REQ-013 Port: d_grant  out  1  data request accepted this cycle.
REQ-014 Port: d_valid  out  1  one-cycle pulse; read data valid or write done.
REQ-015 Port: d_rdata  out  32  data read data.
REQ-016 Port: mem_addr  out  32  address to the single-ported memory.
REQ-017 Port: mem_wdata  out  32  write data to memory.
REQ-018 Port: mem_read / mem_write  out  1 each  memory strobes; never both high.
REQ-019 Port: mem_rdata  in  32  memory read data.
REQ-020 Port: busy  out  1  high in any state other than IDLE.

Function
REQ-021 FSM states: IDLE, ACCESS, RESP; IDLE->ACCESS on grant; ACCESS->RESP when the cycle counter reaches 0; RESP->IDLE unconditionally.
REQ-022 In IDLE with any request pending, exactly one grant is asserted combinationally in that same cycle.
REQ-023 The winner's address, we and wdata are latched at the grant edge; the counter is loaded with LATENCY-1.
REQ-024 In ACCESS: mem_addr/mem_wdata come from the latched values; mem_read = ~we, mem_write = we; the counter decrements each cycle.
REQ-025 On the last ACCESS cycle (counter = 0), mem_rdata is captured into the winner's rdata register for reads.
REQ-026 Writes leave d_rdata unchanged.
REQ-027 RESP asserts the winner's valid for exactly one cycle; strobes are low.
REQ-028 Timing: grant at cycle 0, ACCESS cycles 1..LATENCY, valid at cycle LATENCY+1, next grant no earlier than LATENCY+2.
REQ-029 Requesters hold req, addr, we and wdata until grant; a req still high after its grant is a new request.
REQ-030 Requests in ACCESS or RESP are ignored (no grant) and wait for IDLE.
REQ-031 Outside ACCESS, mem_read = mem_write = 0 and mem_addr/mem_wdata hold their last latched values.
REQ-032 if_rdata and d_rdata hold their value until the next read by the same port.
REQ-033 Only one of if_grant/d_grant may be high per cycle; only one of if_valid/d_valid may be high per cycle.

Reset
REQ-034 While reset is high at a clock edge: state = IDLE, counter = 0, latched addr/wdata/we = 0, rdata registers = 0, round-robin pointer = fetch.
REQ-035 All grants, valids, strobes and busy read 0 in the cycle after the reset edge.
REQ-036 Reset during ACCESS or RESP aborts the transaction; no valid pulse is produced for it.
REQ-037 Grants are suppressed while reset is high.

Configuration
REQ-038 Macro MEM_ARB_RR_EN selects the conflict policy.
REQ-039 Without MEM_ARB_RR_EN, simultaneous if_req and d_req always grant data (fixed priority).
REQ-040 With MEM_ARB_RR_EN, simultaneous requests grant the port not granted last.
REQ-041 Under MEM_ARB_RR_EN, the pointer updates on every grant, conflicting or not; after reset, the first conflict grants data.

Verification
REQ-042 Test: LATENCY=2; if_req, if_addr=0x10, mem returns 0xDEADBEEF -> if_grant cycle 0, mem_read cycles 1-2 with mem_addr=0x10, if_valid cycle 3, if_rdata=0xDEADBEEF.
REQ-043 Test: d_req, d_we=1, d_addr=0x20, d_wdata=0x1234 -> mem_write high 2 cycles with those values; d_valid pulse at cycle 3; d_rdata unchanged.
REQ-044 Test: no macro; if_req and d_req held high together for 3 transactions -> all three grants go to data, fetch starved.
REQ-045 Test: MEM_ARB_RR_EN; both held high -> grant order data, fetch, data, fetch; each grant 4 cycles apart.
REQ-046 Test: reset asserted in cycle 2 of a read -> next cycle busy=0, no valid ever, rdata=0, new request granted immediately.
REQ-047 Test: LATENCY=1; back-to-back fetches -> grants 3 cycles apart, mem_read high exactly 1 cycle each.
